spi_pixel_bridge: RTL
=====================

SPI_PIXEL_BRIDGE -- requirements
Module: spi_pixel_bridge

Interface
REQ-001 Parameter WORD_SIZE, default 24: pixel word width, equal to the SPI core word size.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, minimum 2: number of RX FIFO entries.
REQ-003 clk_i  input  1  system clock; must run at 8x SPI sck or faster.
REQ-004 nreset_i  input  1  reset, asynchronous, active-low.
REQ-005 spi_done_i  input  1  word-done pulse from the SPI core, in the sck domain.
REQ-006 spi_rx_data_i  input  WORD_SIZE  received word from the SPI core.
REQ-007 spi_tx_data_o  output  WORD_SIZE  next word for the SPI core to shift out.
REQ-008 m_data_o / m_valid_o / m_ready_i  out/out/in  WORD_SIZE/1/1  received-pixel stream to the grayscale stage.
REQ-009 s_data_i / s_valid_i / s_ready_o  in/in/out  WORD_SIZE/1/1  result-pixel stream from the Sobel stage.
REQ-010 overflow_o  output  1  sticky flag: an RX word was dropped.
REQ-011 underrun_o  output  1  sticky flag: a TX slot was sent without fresh data.

Function
REQ-012 The block shall synchronise spi_done_i through 2 flops plus 1 edge-detect flop; a rising edge produces a 1-cycle event ev.
REQ-013 The capture FSM shall have three states: IDLE, CAPTURE, PUSH; transitions are IDLE->CAPTURE on ev, CAPTURE->PUSH unconditionally, and PUSH->IDLE unconditionally.
REQ-014 In CAPTURE the block shall register spi_rx_data_i; the system guarantees the data is stable for 4 clk_i cycles after spi_done_i rises.
REQ-015 In PUSH the block shall write the captured word into the RX FIFO if it is not full.
REQ-016 If the FIFO is full in PUSH, the block shall discard the new word and set overflow_o; FIFO contents stay unchanged.
REQ-017 An ev arriving while the FSM is not in IDLE shall be ignored and shall set overflow_o.
REQ-018 Latency: a word pushed into an empty FIFO shall make m_valid_o high on the cycle after PUSH, i.e. 3 clk_i cycles after ev.
REQ-019 Output stream: m_data_o equals the FIFO head while m_valid_o=1; the head is popped on any cycle with m_valid_o and m_ready_i both high.
REQ-020 Push and pop in the same cycle shall both succeed; a full FIFO popped during PUSH shall accept the new word.
REQ-021 FIFO pointers shall wrap modulo FIFO_DEPTH; full/empty shall be distinguished by an extra pointer bit.
REQ-022 TX holding register: s_ready_o=1 while the register is empty; it loads s_data_i when s_valid_i and s_ready_o are both high.
REQ-023 In PUSH the block shall transfer the holding register to spi_tx_data_o and mark the register empty.
REQ-024 If the holding register is empty in PUSH, spi_tx_data_o shall become 0 and underrun_o shall be set.
REQ-025 spi_tx_data_o shall change only in PUSH.
REQ-026 s_ready_o shall fall on the cycle after a load; a load and a PUSH in the same cycle shall forward s_data_i directly to spi_tx_data_o, leaving the register empty.

Reset
REQ-027 Asserting nreset_i shall immediately clear all state: FSM=IDLE, FIFO empty, synchroniser flops 0, m_valid_o=0, m_data_o=0, spi_tx_data_o=0, s_ready_o=1, overflow_o=0, underrun_o=0.
REQ-028 Reset asserted mid-CAPTURE or mid-PUSH shall abort the operation with no FIFO write.
REQ-029 After reset release, a spi_done_i that is already high shall not generate ev until it has gone low and risen again.

Configuration
REQ-030 Macro SPI_BRIDGE_STATUS_EN defined: overflow_o and underrun_o behave per REQ-016, REQ-017 and REQ-024.
REQ-031 Macro SPI_BRIDGE_STATUS_EN undefined: overflow_o and underrun_o ports remain but are tied 0; dropping and zero-fill behaviour is unchanged.

Verification
REQ-032 Single word: reset, preload s_data_i=0x00FF00, pulse spi_done_i with rx=0xA1B2C3 -> m_valid_o high at ev+3 with m_data_o=0xA1B2C3, spi_tx_data_o=0x00FF00, s_ready_o back to 1.
REQ-033 Overflow: m_ready_i=0, send 5 words 1..5 -> FIFO holds 1..4, overflow_o=1; drain returns 1,2,3,4 in order.
REQ-034 Underrun: no s_valid_i, send one word -> spi_tx_data_o=0, underrun_o=1 (0 when SPI_BRIDGE_STATUS_EN is undefined).
REQ-035 Simultaneous push/pop: FIFO full, m_ready_i=1 during PUSH -> word accepted, count stays 4, overflow_o=0.
REQ-036 Reset mid-PUSH: assert nreset_i during PUSH -> m_valid_o=0, spi_tx_data_o=0; spi_done_i held high after release -> no ev.
REQ-037 Wrap: stream 16 words with m_ready_i=1 throughout -> all 16 received in order, no flags set.

Source files
------------

// File: rtl/spi_pixel_bridge.sv
// spi_pixel_bridge: SPI word-done capture into an RX FIFO, plus TX holding register for outbound pixels.
// Status flags are active only with SPI_BRIDGE_STATUS_EN defined. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module spi_pixel_bridge #(
  parameter int WORD_SIZE  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 spi_done_i,
  input  logic [WORD_SIZE-1:0] spi_rx_data_i,
  output logic [WORD_SIZE-1:0] spi_tx_data_o,
  output logic [WORD_SIZE-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  input  logic [WORD_SIZE-1:0] s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic                 overflow_o,
  output logic                 underrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PUSH    = 2'd2
  } state_t;

  state_t               state_q;
  logic [WORD_SIZE-1:0] rx_q;

  logic       done_s1_q, done_s2_q, done_s3_q;
  logic [1:0] prime_q;
  logic       armed_q;
  logic       ev;

  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 full, empty, push, pop;

  logic [WORD_SIZE-1:0] hold_q;
  logic                 hold_full_q;
  logic [WORD_SIZE-1:0] spi_tx_data_q;
  logic                 load;

  // armed_q requires spi_done_i to be seen low after reset, so a level held through reset gives no event
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      done_s3_q <= 1'b0;
      prime_q   <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      done_s1_q <= spi_done_i;
      done_s2_q <= done_s1_q;
      done_s3_q <= done_s2_q;
      prime_q   <= {prime_q[0], 1'b1};
      if (prime_q[1] && !done_s2_q)
        armed_q <= 1'b1;
    end
  end

  assign ev = done_s2_q & ~done_s3_q & armed_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      rx_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (ev) state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          rx_q    <= spi_rx_data_i;
          state_q <= ST_PUSH;
        end
        ST_PUSH:    state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = m_valid_o & m_ready_i;
  // A concurrent pop frees the head slot, so a full FIFO can still take the push
  assign push  = (state_q == ST_PUSH) && (!full || pop);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= rx_q;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign m_valid_o = ~empty;
  assign m_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign s_ready_o = ~hold_full_q;
  assign load      = s_valid_i & s_ready_o;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      spi_tx_data_q <= '0;
    end else if (state_q == ST_PUSH) begin
      hold_full_q <= 1'b0;
      if (load)
        spi_tx_data_q <= s_data_i;
      else if (hold_full_q)
        spi_tx_data_q <= hold_q;
      else
        spi_tx_data_q <= '0;
    end else if (load) begin
      hold_q      <= s_data_i;
      hold_full_q <= 1'b1;
    end
  end

  assign spi_tx_data_o = spi_tx_data_q;

`ifdef SPI_BRIDGE_STATUS_EN
  logic overflow_q, underrun_q;
  logic overflow_set, underrun_set;

  assign overflow_set = ((state_q == ST_PUSH) && full && !pop) ||
                        (ev && (state_q != ST_IDLE));
  assign underrun_set = (state_q == ST_PUSH) && !hold_full_q && !load;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | overflow_set;
      underrun_q <= underrun_q | underrun_set;
    end
  end

  assign overflow_o = overflow_q;
  assign underrun_o = underrun_q;
`else
  assign overflow_o = 1'b0;
  assign underrun_o = 1'b0;
`endif

endmodule

`default_nettype wire
